// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and width helpers for the memory-port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Word-index width inside a refill block.
  function automatic int idx_w(input int block_words);
    return $clog2(block_words);
  endfunction

  // Client-index width; never zero so a single-client build still has a pointer bit.
  function automatic int client_w(input int n_clients);
    return (n_clients <= 1) ? 1 : $clog2(n_clients);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - one-hot winner selection (round-robin, or fixed priority under ARB_FIXED_PRIO_EN)
module rr_pick #(
  parameter int N  = 2,
  parameter int CW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [CW-1:0] idx_o,
  output logic          any_o
);

  int   start;
  logic found;

  // Search from the pointer upward, then wrap to the low indices.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    start   = 0;
`else
    start   = int'(ptr_i);
`endif
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= start)) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = CW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = CW'(i);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-client memory-port arbiter with block-read streaming; ARB_FIXED_PRIO_EN selects fixed priority
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int N_CLIENTS   = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLIENTS-1:0]          req,
  input  logic [N_CLIENTS-1:0]          req_wr,
  input  logic [N_CLIENTS*ADDR_W-1:0]   req_addr,
  input  logic [N_CLIENTS*DATA_W-1:0]   req_wdata,
  output logic [N_CLIENTS-1:0]          grant,
  output logic                          fill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]             fill_data,
  output logic [N_CLIENTS-1:0]          done,
  output logic                          busy,
  output logic                          mem_enable,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_data_out,
  input  logic                          mem_data_valid
);

  localparam int IDX_W = idx_w(BLOCK_WORDS);
  localparam int CW    = client_w(N_CLIENTS);
  localparam int CNT_W = IDX_W + 1;

  arb_state_t            state_q;
  logic [N_CLIENTS-1:0]  grant_q, done_q;
  logic                  mem_enable_q, mem_wr_q;
  logic [ADDR_W-1:0]     mem_addr_q, addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      issue_cnt_q;
  logic [CNT_W-1:0]      rcv_cnt_q;
  logic                  wr_q;

  logic [N_CLIENTS-1:0]  pick_oh;
  logic [CW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  win_wr;
  logic [ADDR_W-1:0]     win_addr;
  logic [DATA_W-1:0]     win_wdata;
  logic                  last_fill;

  // Word address within the block: block base, word index, byte-in-word zero.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [IDX_W-1:0]  c);
    return {a[ADDR_W-1:IDX_W+1], c, 1'b0};
  endfunction

  rr_pick #(
    .N  (N_CLIENTS),
    .CW (CW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Route the winning client's command fields to the latch point.
  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (pick_oh[i]) begin
        win_wr    = req_wr[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer moves just past the winner; fixed priority pins it at zero.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`else
    rr_ptr_d = (pick_idx == CW'(N_CLIENTS - 1)) ? '0 : pick_idx + CW'(1);
`endif
  end

  // Read returns only count while a block read is in flight.
  assign fill_valid = mem_data_valid && !wr_q &&
                      ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign fill_idx   = rcv_cnt_q[IDX_W-1:0];
  assign fill_data  = mem_data_out;
  assign last_fill  = fill_valid && (rcv_cnt_q == CNT_W'(BLOCK_WORDS - 1));

  // Transaction FSM: word 0 (or the write) is registered on the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      rr_ptr_q     <= '0;
      issue_cnt_q  <= '0;
      rcv_cnt_q    <= '0;
    end else begin
      done_q <= '0;
      if (fill_valid) rcv_cnt_q <= rcv_cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          mem_enable_q <= 1'b0;
          mem_wr_q     <= 1'b0;
          if (pick_any) begin
            grant_q      <= pick_oh;
            wr_q         <= win_wr;
            addr_q       <= win_addr;
            mem_wdata_q  <= win_wdata;
            rr_ptr_q     <= rr_ptr_d;
            rcv_cnt_q    <= '0;
            mem_enable_q <= 1'b1;
            state_q      <= ST_ISSUE;
            if (win_wr) begin
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= win_addr;
              issue_cnt_q <= '0;
            end else begin
              mem_addr_q  <= word_addr(win_addr, '0);
              issue_cnt_q <= IDX_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (wr_q) begin
            mem_enable_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            done_q       <= grant_q;
            state_q      <= ST_DONE;
          end else begin
            mem_addr_q  <= word_addr(addr_q, issue_cnt_q);
            issue_cnt_q <= issue_cnt_q + IDX_W'(1);
            if (issue_cnt_q == IDX_W'(BLOCK_WORDS - 1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          mem_enable_q <= 1'b0;
          if (last_fill || (rcv_cnt_q == CNT_W'(BLOCK_WORDS))) begin
            done_q  <= grant_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign mem_enable = mem_enable_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - scoreboard bench for mem_arbiter_rr with a latency-4 memory model
module tb_mem_arbiter_rr;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } fill_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_wr = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  grant, done;
  logic        fill_valid, busy, mem_enable, mem_wr;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_data_out;
  logic        mem_data_valid;
  logic        stray = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .N_CLIENTS   (2),
    .ADDR_W      (16),
    .DATA_W      (16),
    .BLOCK_WORDS (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .grant          (grant),
    .fill_valid     (fill_valid),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .done           (done),
    .busy           (busy),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid)
  );

  // Memory model: reads return addr ^ 5A5A four cycles after the command is visible.
  logic [3:0]  pv;
  logic [15:0] pd [4];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[2:0], mem_enable && !mem_wr};
      pd[0] <= mem_addr ^ 16'h5A5A;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
  end
  assign mem_data_valid = pv[3] | stray;
  assign mem_data_out   = pd[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic sb_on  = 1'b1;
  int st_issue, st_fill, st_lastfill, st_done;

  mem_t        exp_mem[$];
  fill_t       exp_fill[$];
  logic [1:0]  exp_done[$];
  mem_t        m;
  fill_t       f;
  logic [1:0]  d;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_read(input int c, input logic [15:0] a);
    logic [15:0] base;
    base = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      exp_mem.push_back('{wr: 1'b0, addr: base + 16'(2*i), data: 16'h0});
      exp_fill.push_back('{idx: 3'(i), data: (base + 16'(2*i)) ^ 16'h5A5A});
    end
    exp_done.push_back(2'(1 << c));
  endtask

  task automatic push_write(input int c, input logic [15:0] a, input logic [15:0] wd);
    exp_mem.push_back('{wr: 1'b1, addr: a, data: wd});
    exp_done.push_back(2'(1 << c));
  endtask

  task automatic arm();
    st_issue = -1; st_fill = -1; st_lastfill = -1; st_done = -1;
  endtask

  // One transaction from one client; drop_at > 0 lowers req in that cycle.
  task automatic run_txn(input int c, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input int drop_at, output int t0);
    int target;
    target = n_done + 1;
    if (wr) push_write(c, a, wd); else push_read(c, a);
    req_wr[c] = wr;
    req_addr[c*16 +: 16]  = a;
    req_wdata[c*16 +: 16] = wd;
    req[c] = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (drop_at > 0 && cyc == t0 + drop_at) req[c] = 1'b0;
      if (n_done >= target) break;
    end
    req[c] = 1'b0;
    check("txn_done_count", n_done, target);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst && sb_on) begin
      if (mem_enable) begin
        if (st_issue < 0) st_issue = cyc;
        if (exp_mem.size() == 0) check("mem_unexpected", 1, 0);
        else begin
          m = exp_mem.pop_front();
          check("mem_wr", mem_wr, m.wr);
          check("mem_addr", mem_addr, m.addr);
          if (m.wr) check("mem_wdata", mem_wdata, m.data);
        end
      end
      if (fill_valid) begin
        if (st_fill < 0) st_fill = cyc;
        st_lastfill = cyc;
        if (exp_fill.size() == 0) check("fill_unexpected", 1, 0);
        else begin
          f = exp_fill.pop_front();
          check("fill_idx", fill_idx, f.idx);
          check("fill_data", fill_data, f.data);
        end
      end
      if (done != 2'b00) begin
        st_done = cyc;
        n_done++;
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          d = exp_done.pop_front();
          check("done", done, d);
          check("grant_at_done", grant, d);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, target;
    arm();
    repeat (2) @(posedge clk);
    #2;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_fill_valid", fill_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Contention from reset: client 0 reads, client 1 writes, both held high.
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) push_read(0, 16'h1000);
`else
    for (int k = 0; k < 2; k++) begin
      push_read(0, 16'h1000);
      push_write(1, 16'h0200, 16'h2222);
    end
`endif
    target = n_done + 4;
    req_wr = 2'b10;
    req_addr = {16'h0200, 16'h1000};
    req_wdata = {16'h2222, 16'h0000};
    req = 2'b11;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (n_done >= target) break;
    end
    req = 2'b00;
    check("contention_dones", n_done, target);
    repeat (2) @(posedge clk);
    #2;

    // Stray return while idle must not surface or advance the counter.
    stray = 1'b1;
    #1;
    check("stray_fill_valid", fill_valid, 0);
    check("stray_fill_idx", fill_idx, 0);
    check("stray_busy", busy, 0);
    @(posedge clk); #2;
    stray = 1'b0;
    @(posedge clk); #2;

    // Single read, client 1, addr 0x0036.
    arm();
    run_txn(1, 1'b0, 16'h0036, 16'h0, 0, t0);
    check("rd_first_issue_cyc", st_issue, t0 + 1);
    check("rd_first_fill_cyc", st_fill, t0 + 5);
    check("rd_last_fill_cyc", st_lastfill, t0 + 12);
    check("rd_done_cyc", st_done, t0 + 13);
    check("rd_idle_after", busy, 0);

    // Single write, client 1, 0xBEEF to 0x0104.
    arm();
    run_txn(1, 1'b1, 16'h0104, 16'hBEEF, 0, t0);
    check("wr_issue_cyc", st_issue, t0 + 1);
    check("wr_done_cyc", st_done, t0 + 2);
    check("wr_no_fill", st_fill, -1);
    check("wr_idle_cycle3", busy, 0);

    // Client 0 drops req in cycle 3 of a read.
    run_txn(0, 1'b0, 16'h0100, 16'h0, 3, t0);

    // Reset in cycle 5 of a read.
    sb_on = 1'b0;
    req_wr[1] = 1'b0;
    req_addr[31:16] = 16'h0400;
    req[1] = 1'b1;
    t0 = cyc;
    while (cyc < t0 + 5) begin
      @(posedge clk); #2;
    end
    check("mid_read_busy", busy, 1);
    rst = 1'b1;
    req[1] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    check("rst_mid_grant", grant, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem_enable", mem_enable, 0);
    sb_on = 1'b1;
    @(posedge clk); #2;

    run_txn(0, 1'b1, 16'h0300, 16'h1234, 0, t0);
    run_txn(1, 1'b0, 16'h0ABC, 16'h0, 0, t0);
    repeat (3) @(posedge clk);
    #2;
    check("exp_mem_left", exp_mem.size(), 0);
    check("exp_fill_left", exp_fill.size(), 0);
    check("exp_done_left", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
